keypad_decoder: RTL and testbench

Consumes the one-hot column sweep driven onto the 4x4 matrix keypad and the raw row lines returned by the keypad. It synchronises the rows and aligns them with the column that produced them. It debounces a single key press and emits a one-cycle key event with a hex key value. It sits directly downstream of the column sweep stage and feeds the display/register path.

---
 rtl/keypad_pkg.sv | 28 ++
 rtl/keypad_sync.sv | 29 ++
 rtl/keypad_decoder.sv | 179 +++++++++++++++++
 tb/tb_keypad_decoder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Purpose: shared types and constants for the keypad decoder (FSM states, keymap, index helper).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2
    } kp_state_e;

    // KEYMAP[row][col]: rows top to bottom, columns left to right. '*' decodes to E, '#' to F.
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Index of the set bit of a one-hot nibble. The caller guarantees one-hot input.
    function automatic logic [1:0] oh_to_idx(input logic [3:0] oh);
        oh_to_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) oh_to_idx = 2'(i);
        end
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Purpose: N-stage flop synchroniser for an asynchronous bus, reset to a preset value.
// Latency: STAGES cycles from d_i to q_o.
// Backpressure: none; samples every cycle.
// Ports: clk, rst_n (async active-low), d_i (async bus in), q_o (synchronised bus out).
module keypad_sync #(
    parameter int               WIDTH  = 4,
    parameter int               STAGES = 2,
    parameter logic [WIDTH-1:0] PRESET = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= PRESET;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/keypad_decoder.sv
// Purpose: align keypad rows with the column sweep, debounce one key, emit a hex key event.
// Latency: DEBOUNCE_COUNT candidate-column observations + 1 cycle, plus SYNC_STAGES from pins.
// Backpressure: none; key_valid is a single-cycle pulse that the consumer must take.
// Ports: clk, rst_n (async active-low), col (sweep drive), row (raw rows),
//        key_valid (press pulse), key_value (last accepted key), key_held (press active).
module keypad_decoder
    import keypad_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int ROWS           = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_COUNT = 8,
    parameter int COL_ACTIVE_LOW = 0,
    parameter int ROW_ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] col,
    input  logic [ROWS-1:0]  row,
    output logic             key_valid,
    output logic [3:0]       key_value,
    output logic             key_held
);

    localparam int             CW       = $clog2(DEBOUNCE_COUNT + 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE_COUNT);
    localparam logic [ROWS-1:0] ROW_IDLE = (ROW_ACTIVE_LOW != 0) ? {ROWS{1'b1}} : {ROWS{1'b0}};

    // ---------------- alignment ----------------
    logic [WIDTH-1:0] col_norm;
    logic [WIDTH-1:0] col_pipe_q [SYNC_STAGES];
    logic [WIDTH-1:0] col_d;
    logic [ROWS-1:0]  row_s;
    logic [ROWS-1:0]  row_act;

    assign col_norm = (COL_ACTIVE_LOW != 0) ? ~col : col;

    // Column copy delayed by the same depth as the row synchroniser so each
    // synchronised row sample is paired with the column that produced it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) col_pipe_q[i] <= '0;
        end else begin
            col_pipe_q[0] <= col_norm;
            for (int i = 1; i < SYNC_STAGES; i++) col_pipe_q[i] <= col_pipe_q[i-1];
        end
    end

    assign col_d = col_pipe_q[SYNC_STAGES-1];

    keypad_sync #(
        .WIDTH  (ROWS),
        .STAGES (SYNC_STAGES),
        .PRESET (ROW_IDLE)
    ) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (row),
        .q_o   (row_s)
    );

    assign row_act = (ROW_ACTIVE_LOW != 0) ? ~row_s : row_s;

    // ---------------- observation decode ----------------
    logic obs_valid, row_hit, any_row, hit, cand_obs, same_hit;
    logic [3:0] hit_key;

    kp_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [WIDTH-1:0]  cand_col_q, cand_col_d;
    logic [ROWS-1:0]   cand_row_q, cand_row_d;
    logic [3:0]        cand_key_q, cand_key_d;
    logic              key_valid_q, key_valid_d;
    logic [3:0]        key_value_q, key_value_d;
    logic              key_held_q, key_held_d;
    logic              accept;

    assign obs_valid = $onehot(col_d);
    assign row_hit   = $onehot(row_act);
    assign any_row   = |row_act;
    assign hit       = obs_valid && row_hit;
    assign cand_obs  = obs_valid && (col_d == cand_col_q);
    assign same_hit  = row_hit && (row_act == cand_row_q);
    assign hit_key   = KEYMAP[oh_to_idx(4'(row_act))][oh_to_idx(4'(col_d))];
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (hit) state_d = (DEBOUNCE_COUNT == 1) ? HELD : PRESS_DB;
            end
            PRESS_DB: begin
                // Only the candidate column is judged; other columns carry no news about this key.
                if (cand_obs) begin
                    if (same_hit) begin
                        if (cnt_inc == CNT_MAX) state_d = HELD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HELD: begin
                if (cand_obs && !any_row && (cnt_inc == CNT_MAX)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        accept      = (state_q != HELD) && (state_d == HELD);
        key_valid_d = accept;
        key_held_d  = (state_d == HELD);
        key_value_d = key_value_q;
        // A single-count debounce accepts straight from IDLE, before the candidate is latched.
        if (accept) key_value_d = (state_q == IDLE) ? hit_key : cand_key_q;
    end

    // ---------------- counter and candidate ----------------
    always_comb begin
        cnt_d      = cnt_q;
        cand_col_d = cand_col_q;
        cand_row_d = cand_row_q;
        cand_key_d = cand_key_q;
        if ((state_q == IDLE) && hit) begin
            cand_col_d = col_d;
            cand_row_d = row_act;
            cand_key_d = hit_key;
        end
        if (state_d != state_q) begin
            // The entering hit already counts as the first match of a press.
            cnt_d = (state_d == PRESS_DB) ? CW'(1) : '0;
        end else if (cand_obs) begin
            case (state_q)
                PRESS_DB: if (same_hit) cnt_d = cnt_inc;
                HELD: begin
                    // Other rows in the candidate column without the held row neither
                    // advance nor restart the release count.
                    if (!any_row)                      cnt_d = cnt_inc;
                    else if (|(row_act & cand_row_q))  cnt_d = '0;
                end
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            cand_col_q  <= '0;
            cand_row_q  <= '0;
            cand_key_q  <= '0;
            key_valid_q <= 1'b0;
            key_value_q <= '0;
            key_held_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            cand_col_q  <= cand_col_d;
            cand_row_q  <= cand_row_d;
            cand_key_q  <= cand_key_d;
            key_valid_q <= key_valid_d;
            key_value_q <= key_value_d;
            key_held_q  <= key_held_d;
        end
    end

    assign key_valid = key_valid_q;
    assign key_value = key_value_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_decoder.sv
// Purpose: scoreboard bench for keypad_decoder with a behavioural 4x4 keypad and rotating sweep.
// Latency: expects each press event 15 cycles after the press lands on its column (DEBOUNCE_COUNT=4).
// Backpressure: none; monitor consumes every key_valid pulse.
module tb_keypad_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] col;
    logic [3:0] row;
    logic       key_valid;
    logic [3:0] key_value;
    logic       key_held;

    always #5 clk = ~clk;

    keypad_decoder #(
        .WIDTH          (4),
        .ROWS           (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_COUNT (4),
        .COL_ACTIVE_LOW (0),
        .ROW_ACTIVE_LOW (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col       (col),
        .row       (row),
        .key_valid (key_valid),
        .key_value (key_value),
        .key_held  (key_held)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Keypad model: bit r*4+c pressed shorts column c to row r; rows idle high.
    logic [15:0] key_mask = '0;
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_mask[r*4+c] && col[c]) row[r] = 1'b0;
    end

    // Column sweep rotates one position every cycle.
    initial begin
        col = 4'b0001;
        forever begin
            @(negedge clk);
            col = {col[2:0], col[3]};
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [3:0] exp_q[$];
    int n_valid = 0, last_valid_cyc = 0, n_fall = 0, last_fall_cyc = 0;
    logic held_prev = 1'b0;

    initial begin
        logic [3:0] exp_v;
        forever begin
            @(negedge clk);
            if (key_valid) begin
                n_valid++;
                last_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_event: key_valid with key_value=0x%0h, none expected", key_value);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("event_value", int'(key_value), int'(exp_v));
                    check("held_at_event", int'(key_held), 1);
                end
            end
            if (held_prev && !key_held) begin
                n_fall++;
                last_fall_cyc = cyc;
            end
            held_prev = key_held;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_col(input logic [3:0] c);
        int i = 0;
        do begin
            @(negedge clk); #1;
            i++;
        end while (col != c && i < 16);
    endtask

    task automatic wait_valid(input string name, input int base, input int budget);
        int i = 0;
        while (n_valid == base && i < budget) begin
            @(negedge clk); #1;
            i++;
        end
        n_tests++;
        if (n_valid == base) begin
            n_fail++;
            $display("FAIL %s: no key_valid within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_fall(input string name, input int base, input int budget);
        int i = 0;
        while (n_fall == base && i < budget) begin
            @(negedge clk); #1;
            i++;
        end
        n_tests++;
        if (n_fall == base) begin
            n_fail++;
            $display("FAIL %s: key_held did not fall within %0d cycles", name, budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int t0, base, fbase, bad;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", int'(key_valid), 0);
        check("rst_held",  int'(key_held), 0);
        check("rst_value", int'(key_value), 0);
        rst_n = 1'b1;

        // 1: idle keypad stays quiet
        bad = 0;
        repeat (200) begin
            @(negedge clk); #1;
            if (key_valid || key_held || key_value != 4'h0) bad++;
        end
        check("idle_quiet_cycles_bad", bad, 0);

        // 2: key 5 (row1, col1)
        base = n_valid;
        wait_col(4'b0010);
        key_mask[5] = 1'b1;
        t0 = cyc;
        exp_q.push_back(4'h5);
        wait_valid("k5_event", base, 40);
        check("k5_latency", last_valid_cyc - t0, 15);
        repeat (40) @(negedge clk);
        #1;
        check("k5_held", int'(key_held), 1);
        check("k5_value", int'(key_value), 5);
        fbase = n_fall;
        wait_col(4'b0010);
        key_mask[5] = 1'b0;
        t0 = cyc;
        wait_fall("k5_release", fbase, 40);
        check("k5_release_latency", last_fall_cyc - t0, 15);
        check("k5_pulse_count", n_valid - base, 1);

        // 3: bouncing '#' (row3, col2): 2 sweeps on, 1 off, then steady
        repeat (6) @(negedge clk);
        base = n_valid;
        wait_col(4'b0100);
        key_mask[14] = 1'b1;
        wait_col(4'b0100);
        wait_col(4'b0100);
        key_mask[14] = 1'b0;
        wait_col(4'b0100);
        key_mask[14] = 1'b1;
        t0 = cyc;
        exp_q.push_back(4'hF);
        wait_valid("hash_event", base, 60);
        check("hash_latency", last_valid_cyc - t0, 15);
        repeat (20) @(negedge clk);
        #1;
        check("hash_pulse_count", n_valid - base, 1);
        check("hash_value", int'(key_value), 15);
        fbase = n_fall;
        key_mask[14] = 1'b0;
        wait_fall("hash_release", fbase, 40);

        // 4: keys 1 and 4 together, then release 4
        repeat (6) @(negedge clk);
        base = n_valid;
        wait_col(4'b0001);
        key_mask[0] = 1'b1;
        key_mask[4] = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check("dual_no_event", n_valid - base, 0);
        wait_col(4'b0001);
        key_mask[4] = 1'b0;
        t0 = cyc;
        exp_q.push_back(4'h1);
        wait_valid("k1_event", base, 40);
        check("k1_latency", last_valid_cyc - t0, 15);
        fbase = n_fall;
        key_mask[0] = 1'b0;
        wait_fall("k1_release", fbase, 40);

        // 6: async reset during PRESS_DB (cnt=3), key kept pressed
        repeat (6) @(negedge clk);
        base = n_valid;
        wait_col(4'b0010);
        key_mask[5] = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_value", int'(key_value), 0);
        check("arst_held",  int'(key_held), 0);
        check("arst_valid", int'(key_valid), 0);
        repeat (4) @(negedge clk);
        check("arst_no_event", n_valid - base, 0);
        wait_col(4'b0010);
        rst_n = 1'b1;
        t0 = cyc;
        exp_q.push_back(4'h5);
        wait_valid("arst_event", base, 40);
        check("arst_full_debounce", last_valid_cyc - t0, 15);
        fbase = n_fall;
        key_mask[5] = 1'b0;
        wait_fall("arst_release", fbase, 40);

        // 5: hold D, press 0 during HELD
        repeat (6) @(negedge clk);
        base = n_valid;
        wait_col(4'b1000);
        key_mask[15] = 1'b1;
        exp_q.push_back(4'hD);
        wait_valid("kd_event", base, 40);
        key_mask[13] = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        check("kd_no_rollover", n_valid - base, 1);
        check("kd_value_kept", int'(key_value), 13);
        fbase = n_fall;
        key_mask[15] = 1'b0;
        key_mask[13] = 1'b0;
        wait_fall("kd_release", fbase, 40);
        repeat (8) @(negedge clk);
        base = n_valid;
        wait_col(4'b0010);
        key_mask[13] = 1'b1;
        t0 = cyc;
        exp_q.push_back(4'h0);
        wait_valid("k0_event", base, 40);
        check("k0_latency", last_valid_cyc - t0, 15);
        #1;
        check("k0_value", int'(key_value), 0);
        fbase = n_fall;
        key_mask[13] = 1'b0;
        wait_fall("k0_release", fbase, 40);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
